// File: rtl/div_pkg.sv
// Shared constants and FSM state encoding for the sequential restoring divider.
package div_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(31);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor_32bit.sv
// 32-bit ripple-free subtractor: Diff = A - B - Bin, Bout set on borrow out of bit 31.
module full_subtractor_32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Bin,
  output logic [31:0] Diff,
  output logic        Bout
);

  assign {Bout, Diff} = {1'b0, A} - {1'b0, B} - 33'(Bin);

endmodule

// File: rtl/restoring_divider_32bit.sv
// Sequential unsigned restoring divider producing one quotient bit per clock.
module restoring_divider_32bit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH_P = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  if (WIDTH_P != 32) begin : g_bad_width
    $error("restoring_divider_32bit only supports a width of 32");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             dbz_q, dbz_d, busy_q, done_q;

  logic [WIDTH-1:0] shifted, diff, r_next, q_next;
  logic             borrow, accept;

  assign shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  full_subtractor_32bit u_sub (
    .A    (shifted),
    .B    (d_q),
    .Bin  (1'b0),
    .Diff (diff),
    .Bout (borrow)
  );

  // The carry out of the shift means the true 33-bit remainder already exceeds D.
  assign accept = r_q[WIDTH-1] | ~borrow;
  assign r_next = accept ? diff : shifted;
  assign q_next = {q_q[WIDTH-2:0], accept};

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            r_d     = '0;
            q_d     = dividend;
            d_d     = divisor;
            count_d = '0;
            dbz_d   = 1'b0;
            state_d = S_CALC;
          end else begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = S_FIN;
          end
        end
      end
      S_CALC: begin
        r_d     = r_next;
        q_d     = q_next;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_ITER) begin
          quotient_d  = q_next;
          remainder_d = r_next;
          state_d     = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FIN);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_32bit.sv
// Directed and random checks of the restoring divider against a scoreboard of expected results.
module tb_restoring_divider_32bit;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  time  last_accept;

  restoring_divider_32bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Issue one division from IDLE, then check latency, busy length, results and done pulse width.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n;
    int   bcnt;
    int   lat;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    last_accept = $time;
    #1 start = 1'b0;
    e.dbz = (b == 32'd0);
    e.q   = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    e.r   = (b == 32'd0) ? a : a % b;
    sb.push_back(e);
    lat  = (b == 32'd0) ? 0 : 32;
    n    = 0;
    bcnt = 0;
    while (!done && n < 40) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      n++;
    end
    if (done && busy) bcnt++;
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(n), 32'(lat));
    check("busy_len", 32'(bcnt), 32'(lat + 1));
    e = sb.pop_front();
    check("quotient", quotient, e.q);
    check("remainder", remainder, e.r);
    check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_clear", 32'(busy), 32'd0);
    check("result_hold", quotient, e.q);
  endtask

  initial begin
    logic [31:0] a, b;
    time         t0;
    logic        saw_done;

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_div(32'd100, 32'd7);
    do_div(32'hFFFF_FFFF, 32'd1);
    do_div(32'hFFFF_FFFF, 32'h8000_0000);
    do_div(32'd5, 32'd0);
    do_div(32'd9, 32'd3);

    // Back-to-back issue: second start lands on the first IDLE cycle after done.
    do_div(32'd12345, 32'd17);
    t0 = last_accept;
    do_div(32'd77, 32'd5);
    check("throughput", 32'(last_accept - t0), 32'd340);

    // Mid-CALC ignored start, then reset abandons the division at iteration 20.
    dividend = 32'd1000;
    divisor  = 32'd10;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    saw_done = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1 saw_done |= done;
    end
    dividend = 32'd7;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_mid_calc", 32'(busy), 32'd1);
    check("quotient_hold_calc", quotient, 32'd15);
    repeat (14) begin
      @(posedge clk);
      #1 saw_done |= done;
    end
    check("no_early_done", 32'(saw_done), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_dbz", 32'(div_by_zero), 32'd0);
    check("arst_quotient", quotient, 32'd0);
    check("arst_remainder", remainder, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1 saw_done |= (done | busy);
    end
    check("no_done_after_reset", 32'(saw_done), 32'd0);
    do_div(32'd1000, 32'd10);

    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = $urandom_range(0, 5000);
        2: a = 32'($urandom) >> $urandom_range(0, 31);
        default: a = 32'h8000_0000 | $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 1000);
        2: b = 32'($urandom) >> $urandom_range(0, 31);
        default: b = 32'h8000_0000 | $urandom;
      endcase
      if (b == 32'd0) b = 32'd1;
      do_div(a, b);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
